// File: rtl/bpsk_pkg.sv
// bpsk_pkg
// Shared definitions for the BPSK frame sequencer: the frame state
// encoding, default frame-geometry values and a small elaboration helper.
package bpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_PAY   = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  localparam int          DEF_SPS         = 16;
  localparam int          DEF_PRE_LEN     = 32;
  localparam int          DEF_PAY_LEN     = 64;
  localparam int          DEF_GUARD_CYC   = 64;
  localparam logic [31:0] DEF_PRE_PATTERN = 32'hAAAA_AAAA;

  // Larger of two integers; used to size the shared bit counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bpsk_symbol_timer.sv
// bpsk_symbol_timer
// Owns the sample-within-symbol counter and the bit-within-phase counter.
// A strobe is granted when the sequencer allows it (run), the sine generator
// has a sample (sine_rdy) and the DAC is free (davdac low).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous return of both counters to zero
//   run           sequencer permits sampling this cycle
//   sine_rdy      sine generator has a sample ready
//   davdac        DAC busy
//   is_pay        selects payload length for the phase-end compare
//   strobe        sample strobe for this cycle
//   symbol_end    strobe on the last sample of a symbol
//   phase_end     symbol_end on the last bit of the current phase
//   bit_cnt       current bit index within the phase
module bpsk_symbol_timer
  import bpsk_pkg::*;
#(
  parameter int SPS     = DEF_SPS,
  parameter int PRE_LEN = DEF_PRE_LEN,
  parameter int PAY_LEN = DEF_PAY_LEN,
  parameter int BW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          run,
  input  logic          sine_rdy,
  input  logic          davdac,
  input  logic          is_pay,
  output logic          strobe,
  output logic          symbol_end,
  output logic          phase_end,
  output logic [BW-1:0] bit_cnt
);

  localparam int            SW        = $clog2(SPS);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SPS - 1);
  localparam logic [BW-1:0] PRE_LAST  = BW'(PRE_LEN - 1);
  localparam logic [BW-1:0] PAY_LAST  = BW'(PAY_LEN - 1);

  logic [SW-1:0] samp_cnt_r;
  logic [BW-1:0] bit_cnt_r;

  // Strobe qualification and boundary flags for the current cycle.
  always_comb begin
    strobe     = run & sine_rdy & ~davdac;
    symbol_end = strobe & (samp_cnt_r == SAMP_LAST);
    if (is_pay) begin
      phase_end = symbol_end & (bit_cnt_r == PAY_LAST);
    end else begin
      phase_end = symbol_end & (bit_cnt_r == PRE_LAST);
    end
  end

  // Sample and bit counters; both hold whenever no strobe is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_cnt_r <= '0;
      bit_cnt_r  <= '0;
    end else if (clear) begin
      samp_cnt_r <= '0;
      bit_cnt_r  <= '0;
    end else if (strobe) begin
      if (symbol_end) begin
        samp_cnt_r <= '0;
        if (phase_end) begin
          bit_cnt_r <= '0;
        end else begin
          bit_cnt_r <= bit_cnt_r + BW'(1);
        end
      end else begin
        samp_cnt_r <= samp_cnt_r + SW'(1);
      end
    end
  end

  assign bit_cnt = bit_cnt_r;

endmodule

// File: rtl/bpsk_frame_sequencer.sv
// bpsk_frame_sequencer
// Frame controller for the BPSK transmit chain. A rising edge on PB starts a
// frame (preamble, payload, guard); a rising edge during preamble/payload
// aborts straight to guard. Symbols are paced by the sine-ready / DAC
// handshake so that each symbol spans exactly SPS DAC samples.
// Every output is a register holding the decision made in the previous
// cycle, so dacdav, mod_en, sine_clk_en and mod_bit stay mutually aligned.
// Optional feature macro: BPSK_SEQ_AWGN_EN (drives the noise injector;
// when undefined en_AWGN and rst_AWGN are held at 0).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   PB                  debounced push-button level
//   data_valid/data_bit payload source; data_ready accepts a bit
//   sine_rdy            sine sample ready; sine_rst/sine_clk_en drive the generator
//   mod_en/mod_bit      modulator enable and symbol bit (1 = 0 deg)
//   davdac              DAC busy; dacdav one-cycle sample strobe
//   en_AWGN/rst_AWGN    noise injector enable and reset
//   busy                not IDLE; frame_done pulse on GUARD->IDLE
//   underrun            sticky payload-stall flag, cleared on next start
module bpsk_frame_sequencer
  import bpsk_pkg::*;
#(
  parameter int                 SPS         = DEF_SPS,
  parameter int                 PRE_LEN     = DEF_PRE_LEN,
  parameter logic [PRE_LEN-1:0] PRE_PATTERN = PRE_LEN'(DEF_PRE_PATTERN),
  parameter int                 PAY_LEN     = DEF_PAY_LEN,
  parameter int                 GUARD_CYC   = DEF_GUARD_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic PB,
  input  logic data_valid,
  input  logic data_bit,
  output logic data_ready,
  input  logic sine_rdy,
  output logic sine_rst,
  output logic sine_clk_en,
  output logic mod_en,
  output logic mod_bit,
  input  logic davdac,
  output logic dacdav,
  output logic en_AWGN,
  output logic rst_AWGN,
  output logic busy,
  output logic frame_done,
  output logic underrun
);

  localparam int          BW         = $clog2(max2(PRE_LEN, PAY_LEN) + 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYC - 1);

  state_t        state_r;
  state_t        state_next_s;
  logic          pb_r;
  logic [15:0]   guard_cnt_r;
  logic          need_bit_r;

  logic          pb_edge_s;
  logic          active_s;
  logic          stall_s;
  logic          fetch_s;
  logic          run_s;
  logic          timer_clear_s;
  logic          is_pay_s;
  logic          guard_done_s;
  logic          strobe_s;
  logic          symbol_end_s;
  logic          phase_end_s;
  logic [BW-1:0] bit_cnt_s;
  logic [PRE_LEN-1:0] pre_shift_s;

  logic sine_rst_r, sine_clk_en_r, mod_en_r, mod_bit_r, dacdav_r;
  logic en_awgn_r, rst_awgn_r, busy_r, frame_done_r, underrun_r;

  logic sine_rst_nx_s, run_en_nx_s, mod_bit_nx_s, dacdav_nx_s;
  logic en_awgn_nx_s, rst_awgn_nx_s, busy_nx_s, frame_done_nx_s;
  logic underrun_nx_s, need_bit_nx_s;

  // Qualifiers shared by the FSM, the timer and the output logic.
  always_comb begin
    pb_edge_s     = PB & ~pb_r;
    active_s      = (state_r == ST_PRE) | (state_r == ST_PAY);
    is_pay_s      = (state_r == ST_PAY);
    // need_bit is only ever set while in PAY, so these are PAY-only.
    stall_s       = need_bit_r & ~data_valid;
    fetch_s       = need_bit_r & data_valid;
    // An abort edge suppresses any strobe in the same cycle.
    run_s         = active_s & ~stall_s & ~pb_edge_s;
    timer_clear_s = ~active_s | pb_edge_s;
    guard_done_s  = (state_r == ST_GUARD) & (guard_cnt_r == GUARD_LAST);
    pre_shift_s   = PRE_PATTERN << bit_cnt_s;
  end

  bpsk_symbol_timer #(
    .SPS     (SPS),
    .PRE_LEN (PRE_LEN),
    .PAY_LEN (PAY_LEN),
    .BW      (BW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (timer_clear_s),
    .run        (run_s),
    .sine_rdy   (sine_rdy),
    .davdac     (davdac),
    .is_pay     (is_pay_s),
    .strobe     (strobe_s),
    .symbol_end (symbol_end_s),
    .phase_end  (phase_end_s),
    .bit_cnt    (bit_cnt_s)
  );

  // State register, PB history and guard counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      // Reset to 1 so a button already held at reset release is not an edge.
      pb_r        <= 1'b1;
      guard_cnt_r <= 16'd0;
    end else begin
      state_r <= state_next_s;
      pb_r    <= PB;
      if ((state_r == ST_GUARD) && !guard_done_s) begin
        guard_cnt_r <= guard_cnt_r + 16'd1;
      end else begin
        guard_cnt_r <= 16'd0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pb_edge_s) begin
          state_next_s = ST_PRE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (pb_edge_s) begin
          state_next_s = ST_GUARD;
        end else if (phase_end_s) begin
          state_next_s = ST_PAY;
        end else begin
          state_next_s = ST_PRE;
        end
      end
      ST_PAY: begin
        if (pb_edge_s || phase_end_s) begin
          state_next_s = ST_GUARD;
        end else begin
          state_next_s = ST_PAY;
        end
      end
      ST_GUARD: begin
        // Button edges are deliberately ignored while the guard runs.
        if (guard_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_GUARD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Next values for every registered output and the payload request flag.
  always_comb begin
    sine_rst_nx_s   = ~active_s | pb_edge_s;
    run_en_nx_s     = run_s;
    dacdav_nx_s     = strobe_s;
    busy_nx_s       = (state_next_s != ST_IDLE);
    frame_done_nx_s = guard_done_s;

    case (state_r)
      ST_PRE: begin
        if (pb_edge_s) begin
          mod_bit_nx_s = 1'b0;
        end else begin
          mod_bit_nx_s = pre_shift_s[PRE_LEN-1];
        end
      end
      ST_PAY: begin
        if (pb_edge_s) begin
          mod_bit_nx_s = 1'b0;
        end else if (fetch_s) begin
          mod_bit_nx_s = data_bit;
        end else begin
          mod_bit_nx_s = mod_bit_r;
        end
      end
      default: begin
        mod_bit_nx_s = 1'b0;
      end
    endcase

    if ((state_r == ST_IDLE) && pb_edge_s) begin
      underrun_nx_s = 1'b0;
    end else if (stall_s) begin
      underrun_nx_s = 1'b1;
    end else begin
      underrun_nx_s = underrun_r;
    end

    // Request a bit on PAY entry and after every PAY symbol but the last.
    if ((state_r == ST_PRE) && phase_end_s) begin
      need_bit_nx_s = 1'b1;
    end else if ((state_r == ST_PAY) && symbol_end_s && !phase_end_s) begin
      need_bit_nx_s = 1'b1;
    end else if (fetch_s) begin
      need_bit_nx_s = 1'b0;
    end else if ((state_next_s != ST_PRE) && (state_next_s != ST_PAY)) begin
      need_bit_nx_s = 1'b0;
    end else begin
      need_bit_nx_s = need_bit_r;
    end

`ifdef BPSK_SEQ_AWGN_EN
    en_awgn_nx_s  = run_s;
    rst_awgn_nx_s = (state_r == ST_IDLE) & pb_edge_s;
`else
    en_awgn_nx_s  = 1'b0;
    rst_awgn_nx_s = 1'b0;
`endif
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sine_rst_r    <= 1'b1;
      sine_clk_en_r <= 1'b0;
      mod_en_r      <= 1'b0;
      mod_bit_r     <= 1'b0;
      dacdav_r      <= 1'b0;
      en_awgn_r     <= 1'b0;
      rst_awgn_r    <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      underrun_r    <= 1'b0;
      need_bit_r    <= 1'b0;
    end else begin
      sine_rst_r    <= sine_rst_nx_s;
      sine_clk_en_r <= run_en_nx_s;
      mod_en_r      <= run_en_nx_s;
      mod_bit_r     <= mod_bit_nx_s;
      dacdav_r      <= dacdav_nx_s;
      en_awgn_r     <= en_awgn_nx_s;
      rst_awgn_r    <= rst_awgn_nx_s;
      busy_r        <= busy_nx_s;
      frame_done_r  <= frame_done_nx_s;
      underrun_r    <= underrun_nx_s;
      need_bit_r    <= need_bit_nx_s;
    end
  end

  assign data_ready  = need_bit_r;
  assign sine_rst    = sine_rst_r;
  assign sine_clk_en = sine_clk_en_r;
  assign mod_en      = mod_en_r;
  assign mod_bit     = mod_bit_r;
  assign dacdav      = dacdav_r;
  assign en_AWGN     = en_awgn_r;
  assign rst_AWGN    = rst_awgn_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_bpsk_frame_sequencer.sv
// Directed bench for bpsk_frame_sequencer with SPS=4, PRE_LEN=4,
// PRE_PATTERN=4'b1010, PAY_LEN=4, GUARD_CYC=8 and payload bits 1,1,0,0.
// Edge numbering: E1 is the first clock edge that samples PB high; n holds
// the number of the most recent edge, outputs are sampled 1 ns after it.
module tb_bpsk_frame_sequencer;

  logic clk = 1'b0;
  logic rst, PB, data_valid, data_bit, data_ready, sine_rdy, sine_rst;
  logic sine_clk_en, mod_en, mod_bit, davdac, dacdav, en_AWGN, rst_AWGN;
  logic busy, frame_done, underrun;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int pay_idx  = 0;
  logic [3:0] pay_bits = 4'b1100;  // sent as 1,1,0,0

`ifdef BPSK_SEQ_AWGN_EN
  localparam logic AWGN_ON = 1'b1;
`else
  localparam logic AWGN_ON = 1'b0;
`endif

  bpsk_frame_sequencer #(
    .SPS(4), .PRE_LEN(4), .PRE_PATTERN(4'b1010), .PAY_LEN(4), .GUARD_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .PB(PB), .data_valid(data_valid), .data_bit(data_bit),
    .data_ready(data_ready), .sine_rdy(sine_rdy), .sine_rst(sine_rst),
    .sine_clk_en(sine_clk_en), .mod_en(mod_en), .mod_bit(mod_bit),
    .davdac(davdac), .dacdav(dacdav), .en_AWGN(en_AWGN), .rst_AWGN(rst_AWGN),
    .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Advance one clock; model the payload source handshake.
  task automatic tick();
    logic xfer;
    xfer = data_ready & data_valid;
    @(posedge clk);
    #1;
    if (xfer) pay_idx = pay_idx + 1;
    data_bit = pay_bits[3 - (pay_idx % 4)];
    n = n + 1;
  endtask

  task automatic begin_frame();
    n = 0;
    pay_idx = 0;
    data_bit = 1'b1;
    PB = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; PB = 1'b1; data_valid = 1'b0; data_bit = 1'b0;
    sine_rdy = 1'b1; davdac = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sine_rst, sine_clk_en, mod_en, mod_bit, dacdav, en_AWGN, rst_AWGN,
         busy, frame_done, underrun, data_ready} !== 11'b100_0000_0000) begin
      failures++;
      $display("FAIL reset_values got=%b want=%b", {sine_rst, sine_clk_en, mod_en,
        mod_bit, dacdav, en_AWGN, rst_AWGN, busy, frame_done, underrun, data_ready},
        11'b100_0000_0000);
    end
    #3 rst = 1'b0;
    // PB held high across reset release must not start a frame.
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || sine_rst !== 1'b1) begin
      failures++;
      $display("FAIL pb_high_at_release busy=%b sine_rst=%b want busy=0 sine_rst=1", busy, sine_rst);
    end
    PB = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    int pulses = 0, fd_n = 0, lvl_bad = 0, first_bad = 0, seq_bad = 0;
    logic [7:0] seq = 8'b1010_1100;
    logic exp_run;
    data_valid = 1'b1; davdac = 1'b0; sine_rdy = 1'b1;
    begin_frame();
    for (int c = 0; c < 50; c++) begin
      tick();
      PB = 1'b0;
      exp_run = (n >= 2 && n <= 33);
      if (mod_en !== exp_run || sine_clk_en !== exp_run || dacdav !== exp_run ||
          sine_rst !== ~exp_run || en_AWGN !== (AWGN_ON & exp_run) ||
          rst_AWGN !== (AWGN_ON & (n == 1)) || busy !== (n <= 40) ||
          frame_done !== (n == 41)) begin
        if (lvl_bad == 0) first_bad = n;
        lvl_bad++;
      end
      if (dacdav === 1'b1) begin
        if (pulses < 32 && mod_bit !== seq[7 - pulses / 4]) seq_bad++;
        pulses++;
      end
      if (frame_done === 1'b1 && fd_n == 0) fd_n = n;
    end
    checks++;
    if (lvl_bad !== 0) begin
      failures++;
      $display("FAIL basic_levels bad_cycles=%0d first_edge=%0d want 0", lvl_bad, first_bad);
    end
    checks++;
    if (pulses !== 32) begin
      failures++;
      $display("FAIL basic_pulses got=%0d want=32", pulses);
    end
    checks++;
    if (seq_bad !== 0) begin
      failures++;
      $display("FAIL basic_mod_bit_seq bad=%0d want 0", seq_bad);
    end
    checks++;
    if (fd_n !== 41) begin
      failures++;
      $display("FAIL basic_frame_done_edge got=%0d want=41", fd_n);
    end
    checks++;
    if (pay_idx !== 4 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL basic_payload xfers=%0d underrun=%b want 4/0", pay_idx, underrun);
    end
  endtask

  task automatic test_davdac_toggle();
    int pulses = 0, fd_n = 0, first_dd = 0, bad = 0;
    logic prev_d;
    data_valid = 1'b1; sine_rdy = 1'b1; davdac = 1'b0;
    begin_frame();
    for (int c = 0; c < 90; c++) begin
      prev_d = davdac;
      tick();
      PB = 1'b0;
      davdac = (n % 2 == 1);
      if (dacdav === 1'b1) begin
        if (prev_d !== 1'b0) bad++;
        if (first_dd == 0) first_dd = n;
        pulses++;
      end
      if (frame_done === 1'b1 && fd_n == 0) fd_n = n;
    end
    davdac = 1'b0;
    checks++;
    if (pulses !== 32 || bad !== 0) begin
      failures++;
      $display("FAIL davdac_pulses got=%0d blocked_violations=%0d want 32/0", pulses, bad);
    end
    checks++;
    if (first_dd !== 3 || fd_n !== 73) begin
      failures++;
      $display("FAIL davdac_timing first=%0d done=%0d want 3/73", first_dd, fd_n);
    end
  endtask

  task automatic test_underrun();
    int pulses = 0, fd_n = 0, stall_cnt = 0, win_dd = 0, ur_bad = 0;
    data_valid = 1'b1; sine_rdy = 1'b1; davdac = 1'b0;
    begin_frame();
    for (int c = 0; c < 60; c++) begin
      tick();
      PB = 1'b0;
      data_valid = !(n >= 21 && n <= 30);
      if (n >= 2 && n <= 42 && sine_clk_en === 1'b0) stall_cnt++;
      if (n >= 22 && n <= 31 && (dacdav !== 1'b0 || mod_en !== 1'b0)) win_dd++;
      if (dacdav === 1'b1) pulses++;
      if (frame_done === 1'b1 && fd_n == 0) fd_n = n;
      if ((n == 21 && underrun !== 1'b0) || (n >= 22 && underrun !== 1'b1)) ur_bad++;
    end
    checks++;
    if (stall_cnt !== 10 || win_dd !== 0) begin
      failures++;
      $display("FAIL underrun_stall clk_en_low=%0d active_in_window=%0d want 10/0", stall_cnt, win_dd);
    end
    checks++;
    if (pulses !== 32 || fd_n !== 51) begin
      failures++;
      $display("FAIL underrun_frame pulses=%0d done=%0d want 32/51", pulses, fd_n);
    end
    checks++;
    if (ur_bad !== 0) begin
      failures++;
      $display("FAIL underrun_flag bad_cycles=%0d want 0", ur_bad);
    end
  endtask

  task automatic test_abort();
    int pulses = 0, fd_n = 0, ent_bad = 0;
    data_valid = 1'b1; sine_rdy = 1'b1; davdac = 1'b0;
    begin_frame();
    for (int c = 0; c < 20; c++) begin
      tick();
      PB = (n == 7 || n == 10);  // abort in PRE, then a press during GUARD
      if (n == 1) begin
        checks++;
        if (underrun !== 1'b0) begin
          failures++;
          $display("FAIL underrun_clear_on_start got=%b want=0", underrun);
        end
      end
      if (n == 8 && (sine_rst !== 1'b1 || mod_en !== 1'b0 || dacdav !== 1'b0 || busy !== 1'b1))
        ent_bad++;
      if (dacdav === 1'b1) pulses++;
      if (frame_done === 1'b1 && fd_n == 0) fd_n = n;
      if (n == 17) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL guard_pb_ignored busy=%b want=0", busy);
        end
      end
    end
    checks++;
    if (pulses !== 6 || ent_bad !== 0) begin
      failures++;
      $display("FAIL abort_entry pulses=%0d entry_bad=%0d want 6/0", pulses, ent_bad);
    end
    checks++;
    if (fd_n !== 16) begin
      failures++;
      $display("FAIL abort_frame_done got=%0d want=16", fd_n);
    end
  endtask

  task automatic test_reset_mid_pay();
    int fd_cnt = 0, busy_cnt = 0;
    data_valid = 1'b1; sine_rdy = 1'b1; davdac = 1'b0;
    begin_frame();
    for (int c = 0; c < 20; c++) begin
      tick();
      PB = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sine_rst, sine_clk_en, mod_en, mod_bit, dacdav, busy, frame_done,
         data_ready} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_mid_pay got=%b want=%b", {sine_rst, sine_clk_en, mod_en,
        mod_bit, dacdav, busy, frame_done, data_ready}, 8'b1000_0000);
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (frame_done === 1'b1) fd_cnt++;
      if (busy !== 1'b0) busy_cnt++;
    end
    checks++;
    if (fd_cnt !== 0 || busy_cnt !== 0) begin
      failures++;
      $display("FAIL reset_no_frame_done done=%0d busy_cycles=%0d want 0/0", fd_cnt, busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_davdac_toggle();
    test_underrun();
    test_abort();
    test_reset_mid_pay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
